// File: rtl/mdu_hilo_unit_if.sv
// mdu_hilo_unit_if: EX-stage issue and pipeline-status bundle between the pipeline and the MDU
interface mdu_hilo_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        md_pending;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master(output start, op, rs, rt, cancel, md_pending, input busy, stall, done, hi, lo);
    modport slave(input start, op, rs, rt, cancel, md_pending, output busy, stall, done, hi, lo);
endinterface

// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit: fixed-latency multiply/divide unit owning the architectural HI/LO registers
module mdu_hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic clk,
    input logic reset,
    mdu_hilo_unit_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0] op_q;
    logic [31:0] a_q, b_q, hi, lo, mag_a, mag_b, q_u, r_u, quo, rem;
    logic [63:0] prod;
    logic acc, is_mul, is_div, start_md, finish, done, busy;
    logic sx, neg_a, neg_b, res_div, div_zero;
    assign acc = bus.start & ~bus.cancel & (state == IDLE);
    assign is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
    assign is_div = bus.op == OP_DIV || bus.op == OP_DIVU;
    assign start_md = acc & (is_mul | is_div);
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        finish = 1'b0;
        if (start_md) begin
            state_next = RUN;
            cnt_next = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (state == RUN) begin
            cnt_next = cnt - CW'(1);
            finish = cnt == CW'(1);
            state_next = finish ? IDLE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            done <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            done <= finish;
        end
    end
    // Signed ops work on magnitudes so that 0x80000000 / -1 needs no special case.
    assign sx = op_q == OP_MULT || op_q == OP_DIV;
    assign res_div = op_q == OP_DIV || op_q == OP_DIVU;
    assign neg_a = sx & a_q[31];
    assign neg_b = sx & b_q[31];
    assign prod = {{32{neg_a}}, a_q} * {{32{neg_b}}, b_q};
    assign mag_a = neg_a ? -a_q : a_q;
    assign mag_b = neg_b ? -b_q : b_q;
    assign div_zero = b_q == 32'd0;
    assign q_u = mag_a / (div_zero ? 32'd1 : mag_b);
    assign r_u = mag_a % (div_zero ? 32'd1 : mag_b);
    assign quo = (neg_a ^ neg_b) ? -q_u : q_u;
    assign rem = neg_a ? -r_u : r_u;
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            if (start_md) begin
                op_q <= bus.op;
                a_q <= bus.rs;
                b_q <= bus.rt;
            end
            if (finish && !(res_div && div_zero))
                {hi, lo} <= res_div ? {rem, quo} : prod;
            else if (acc && bus.op == OP_MTHI)
                hi <= bus.rs;
            else if (acc && bus.op == OP_MTLO)
                lo <= bus.rs;
        end
    end
    assign busy = (state == RUN) | start_md;
    assign bus.busy = busy;
    assign bus.stall = bus.md_pending & busy;
    assign bus.done = done;
    assign bus.hi = hi;
    assign bus.lo = lo;
endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb_mdu_hilo_unit: scoreboard bench with an arithmetic reference model for mdu_hilo_unit
module tb_mdu_hilo_unit;
    localparam logic [3:0] NOOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    exp_t sb[$];
    mdu_hilo_unit_if bus();
    mdu_hilo_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic void ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l);
        longint p, q, r;
        logic [63:0] u;
        h = m_hi;
        l = m_lo;
        if (op == MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {h, l} = p;
        end else if (op == MULTU) begin
            u = {32'd0, a} * {32'd0, b};
            {h, l} = u;
        end else if (op == DIV && b != 0) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            l = q[31:0];
            h = r[31:0];
        end else if (op == DIVU && b != 0) begin
            l = a / b;
            h = a % b;
        end
    endfunction
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_hi", bus.hi, e.hi);
                chk("done_lo", bus.lo, e.lo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic pend, input logic canc, input logic intrude);
        logic md;
        int n;
        logic [31:0] eh, el;
        md = (op >= MULT && op <= DIVU) && !canc;
        n = (op == MULT || op == MULTU) ? 5 : 10;
        bus.start = 1'b1;
        bus.op = op;
        bus.rs = a;
        bus.rt = b;
        bus.cancel = canc;
        bus.md_pending = pend;
        #1;
        chk("busy_issue", bus.busy, md);
        chk("stall_issue", bus.stall, md & pend);
        if (md) begin
            ref_result(op, a, b, eh, el);
            sb.push_back('{hi: eh, lo: el, cyc: cyc + n + 1});
        end
        tick();
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        if (!canc && op == MTHI) m_hi = a;
        if (!canc && op == MTLO) m_lo = a;
        if (md) begin
            for (int i = 1; i <= n; i++) begin
                if (intrude && i == 1) begin
                    bus.start = 1'b1;
                    bus.op = MTHI;
                    bus.rs = 32'h0000_ABCD;
                end
                #1;
                chk("busy_run", bus.busy, 1);
                chk("stall_run", bus.stall, pend);
                chk("done_early", bus.done, 0);
                chk("hi_hold", bus.hi, m_hi);
                chk("lo_hold", bus.lo, m_lo);
                tick();
                bus.start = 1'b0;
            end
            m_hi = eh;
            m_lo = el;
            chk("done_pulse", bus.done, 1);
            chk("busy_done", bus.busy, 0);
            chk("stall_done", bus.stall, 0);
        end else begin
            chk("busy_idle", bus.busy, 0);
            chk("done_idle", bus.done, 0);
        end
        chk("hi_after", bus.hi, m_hi);
        chk("lo_after", bus.lo, m_lo);
        bus.md_pending = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op = NOOP;
        bus.rs = '0;
        bus.rt = '0;
        bus.cancel = 1'b0;
        bus.md_pending = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        reset = 1'b0;
        bus.md_pending = 1'b0;
        tick();
        do_op(MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        do_op(DIVU, 32'd7, 32'd2, 0, 0, 0);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(MTHI, 32'h11, 32'd0, 0, 0, 0);
        do_op(MTLO, 32'h22, 32'd0, 0, 0, 0);
        do_op(DIVU, 32'h1234_5678, 32'd0, 0, 0, 0);
        do_op(DIV, 32'h1234_5678, 32'd0, 1, 0, 0);
        do_op(MULT, 32'd1000, 32'hFFFF_FF00, 1, 0, 0);
        do_op(MULT, 32'd3, 32'd4, 0, 0, 1);
        do_op(MULT, 32'd9, 32'd9, 0, 1, 0);
        do_op(4'd9, 32'hDEAD_BEEF, 32'd1, 1, 0, 0);
        bus.start = 1'b1;
        bus.op = DIV;
        bus.rs = 32'd100;
        bus.rt = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        for (int i = 0; i < 11; i++) begin
            chk("midrst_nodone", bus.done, 0);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 8));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            do_op(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Execution-side multiply/divide unit for the EX stage, holding the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and models fixed latency: 5 cycles for multiply, 10 for divide.
- Drives busy/done toward the pipeline, plus a stall request that freezes any MD-class instruction waiting in decode until the operation retires.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO update for MULT/MULTU
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for DIV/DIVU

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  EX holds a valid MDU instruction this cycle
- i_op  in  4  op code (shared macro file): NOOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; others treated as NOOP
- i_rs  in  32  operand A, or MTHI/MTLO source
- i_rt  in  32  operand B
- i_cancel  in  1  EX instruction is being killed (exception/interrupt); suppresses start this cycle
- i_md_pending  in  1  decode holds an MD-class instruction (mult/div/mthi/mtlo/mfhi/mflo)
- o_busy  out  1  unit occupied
- o_stall  out  1  stall request to the hazard unit
- o_done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- o_hi  out  32  HI register
- o_lo  out  32  LO register

Behaviour:
- Reset: cnt=0, state IDLE, HI=0, LO=0, o_done=0, o_busy=0, o_stall=0. Reset wins over every other input.
- Accept: acc = i_start & ~i_cancel & (state==IDLE).
- Accepted mult/div: latch op, i_rs and i_rt at edge E0; load cnt with MULT_CYCLES or DIV_CYCLES; enter RUN.
- RUN: cnt decrements each edge. At edge E_N (N edges after E0) cnt goes 1->0 and HI/LO load the result. o_done is high for exactly the cycle after E_N; state returns to IDLE at the same edge.
- o_busy = (state==RUN) | (acc & op in {MULT,MULTU,DIV,DIVU}). Combinational, so busy is already high in the issue cycle.
- o_busy falls in the cycle o_done is high. mfhi/mflo in that cycle read the new HI/LO.
- o_stall = i_md_pending & o_busy.
- MTHI/MTLO: when acc, HI (resp. LO) <= i_rs at the next edge. No busy and no done.
- Any i_start while RUN is ignored, with no state or register change. The pipeline should never do this; the unit must stay robust if it does.
- i_cancel only gates acceptance in the cycle it is high. It never aborts an operation already in RUN.
- MULT: {HI,LO} = signed 32x32 -> 64-bit product. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV or DIVU): full DIV_CYCLES latency, o_done pulses, HI and LO keep their prior values.
- The result is computed from latched operands, so operand changes during RUN have no effect.
- Arithmetic may be single-cycle combinational or iterative. HI/LO must not change before E_N.
- Reset mid-operation: cnt=0, HI=LO=0, no o_done pulse; the unit is IDLE in the cycle after reset deasserts.

Test Plan:
- MULT i_rs=0xFFFFFFFD (-3), i_rt=5 -> o_busy high in issue cycle plus 5 more; HI=0xFFFFFFFF, LO=0xFFFFFFF1 with o_done in cycle 6 after issue; no HI/LO change earlier.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles. MULT on the same operands -> HI=0, LO=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU x/0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, o_done pulses, HI=0x11, LO=0x22 unchanged.
- Hazards: MULT issued with i_md_pending=1 -> o_stall high for 6 cycles, low in the o_done cycle. MTHI 0xABCD with i_start during RUN -> HI unchanged. MULT with i_cancel=1 -> o_busy low, no done, HI/LO unchanged.
- Reset asserted 3 cycles into a DIV -> HI=LO=0, o_busy=0, no o_done within the following 10 cycles.
